ccu_ctrl_snoop_dispatch: RTL and testbench

- Front-end sequencer for the CCU snoop unit.
- Accepts one coherent read request at a time and broadcasts an AC snoop to every master port except the initiator. It then collects the CR responses and reduces them into shared, dirty, data_available and first_responder.
- If any snooped cache holds data, it dispatches the request to the snoop unit with op READ_SNP_DATA. Otherwise it forwards the request to the memory path.

---
 rtl/ccu_ctrl_snoop_dispatch.sv | 205 ++++++++++++++++++++
 tb/tb_ccu_ctrl_snoop_dispatch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_ctrl_snoop_dispatch.sv
// Snoop dispatch front-end: broadcasts AC snoops for one coherent read, reduces the CR
// responses and hands the request to the snoop unit (cache hit) or the memory path (miss).
package ccu_ctrl_snoop_dispatch_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
        logic [3:0]  id;
    } ar_chan_t;

    typedef struct packed {
        ar_chan_t ar;
    } mst_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  snoop;
        logic [2:0]  prot;
    } snoop_ac_t;

    typedef struct packed {
        logic [4:0] resp;
    } snoop_cr_t;

    typedef enum logic [1:0] {
        SU_OP_NONE    = 2'd0,
        READ_SNP_DATA = 2'd1
    } su_op_e;
endpackage

// Handshakes: a transfer happens on a cycle where valid and ready are both high; a valid,
// once raised, stays high with stable payload until that cycle, and ready may toggle freely.
module ccu_ctrl_snoop_dispatch #(
    parameter int unsigned NoMstPorts = 4,
    parameter type mst_req_t  = ccu_ctrl_snoop_dispatch_pkg::mst_req_t,
    parameter type snoop_ac_t = ccu_ctrl_snoop_dispatch_pkg::snoop_ac_t,
    parameter type snoop_cr_t = ccu_ctrl_snoop_dispatch_pkg::snoop_cr_t,
    localparam int unsigned MstIdxBits = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  mst_req_t                            req_i,
    input  logic [MstIdxBits-1:0]               initiator_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    output snoop_ac_t [NoMstPorts-1:0]          ac_o,
    output logic [NoMstPorts-1:0]               ac_valid_o,
    input  logic [NoMstPorts-1:0]               ac_ready_i,
    input  snoop_cr_t [NoMstPorts-1:0]          cr_i,
    input  logic [NoMstPorts-1:0]               cr_valid_i,
    output logic [NoMstPorts-1:0]               cr_ready_o,
    output mst_req_t                            ccu_req_holder_o,
    output logic                                su_valid_o,
    input  logic                                su_ready_i,
    output ccu_ctrl_snoop_dispatch_pkg::su_op_e su_op_o,
    output logic                                shared_o,
    output logic                                dirty_o,
    output logic [NoMstPorts-1:0]               data_available_o,
    output logic [MstIdxBits-1:0]               first_responder_o,
    output logic                                mem_valid_o,
    input  logic                                mem_ready_i,
    output logic [2:0]                          dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SEND_AC      = 3'd1,
        WAIT_CR      = 3'd2,
        DISPATCH_SU  = 3'd3,
        DISPATCH_MEM = 3'd4
    } state_e;

    state_e                  state_q;
    mst_req_t                req_q;
    logic [NoMstPorts-1:0]   target_q, ac_done_q, cr_done_q, data_q;
    logic                    shared_q, dirty_q;
    logic [MstIdxBits-1:0]   first_q;

    logic [NoMstPorts-1:0]   target_d, ac_done_d, cr_done_d, data_d, cr_hs;
    logic                    shared_d, dirty_d;
    logic [MstIdxBits-1:0]   first_d;
    logic [NoMstPorts-1:0]   unused_cr_bits;

    always_comb begin
        ac_valid_o = '0;
        cr_ready_o = '0;
        if (state_q == SEND_AC) begin
            ac_valid_o = target_q & ~ac_done_q;
        end
        // A CR is only taken once the AC for that port has been registered as sent.
        if (state_q == SEND_AC || state_q == WAIT_CR) begin
            cr_ready_o = ac_done_q & ~cr_done_q;
        end
    end

    always_comb begin
        cr_hs     = cr_ready_o & cr_valid_i;
        ac_done_d = ac_done_q | (ac_valid_o & ac_ready_i);
        cr_done_d = cr_done_q | cr_hs;
        data_d    = data_q;
        shared_d  = shared_q;
        dirty_d   = dirty_q;
        target_d  = '0;
        first_d   = '0;
        unused_cr_bits = '0;
        for (int i = 0; i < NoMstPorts; i++) begin
            target_d[i]       = (MstIdxBits'(i) != initiator_i);
            unused_cr_bits[i] = cr_i[i].resp[4];
            if (cr_hs[i]) begin
                // An errored response never counts as a data source.
                data_d[i] = cr_i[i].resp[0] & ~cr_i[i].resp[1];
                shared_d  = shared_d | cr_i[i].resp[3];
                dirty_d   = dirty_d | cr_i[i].resp[2];
            end
        end
        for (int i = NoMstPorts - 1; i >= 0; i--) begin
            if (data_d[i]) begin
                first_d = MstIdxBits'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= '0;
            target_q  <= '0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            data_q    <= '0;
            shared_q  <= 1'b0;
            dirty_q   <= 1'b0;
            first_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        req_q     <= req_i;
                        target_q  <= target_d;
                        ac_done_q <= '0;
                        cr_done_q <= '0;
                        data_q    <= '0;
                        shared_q  <= 1'b0;
                        dirty_q   <= 1'b0;
                        first_q   <= '0;
                        state_q   <= (target_d == '0) ? DISPATCH_MEM : SEND_AC;
                    end
                end
                SEND_AC: begin
                    ac_done_q <= ac_done_d;
                    cr_done_q <= cr_done_d;
                    data_q    <= data_d;
                    shared_q  <= shared_d;
                    dirty_q   <= dirty_d;
                    if ((ac_done_d & target_q) == target_q) begin
                        state_q <= WAIT_CR;
                    end
                end
                WAIT_CR: begin
                    cr_done_q <= cr_done_d;
                    data_q    <= data_d;
                    shared_q  <= shared_d;
                    dirty_q   <= dirty_d;
                    if (cr_done_d == target_q) begin
                        first_q <= first_d;
                        state_q <= (|data_d) ? DISPATCH_SU : DISPATCH_MEM;
                    end
                end
                DISPATCH_SU: begin
                    if (su_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                DISPATCH_MEM: begin
                    if (mem_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NoMstPorts; i++) begin
            ac_o[i]       = '0;
            ac_o[i].addr  = req_q.ar.addr;
            ac_o[i].snoop = req_q.ar.snoop;
            ac_o[i].prot  = req_q.ar.prot;
        end
    end

    assign req_ready_o       = (state_q == IDLE);
    assign su_valid_o        = (state_q == DISPATCH_SU);
    assign mem_valid_o       = (state_q == DISPATCH_MEM);
    assign su_op_o           = su_valid_o ? ccu_ctrl_snoop_dispatch_pkg::READ_SNP_DATA
                                          : ccu_ctrl_snoop_dispatch_pkg::SU_OP_NONE;
    assign shared_o          = su_valid_o & shared_q;
    assign dirty_o           = su_valid_o & dirty_q;
    assign data_available_o  = su_valid_o ? data_q : '0;
    assign first_responder_o = su_valid_o ? first_q : '0;
    assign ccu_req_holder_o  = req_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_ccu_ctrl_snoop_dispatch.sv
// Bench for ccu_ctrl_snoop_dispatch: directed scenarios plus randomized transactions,
// each checked against a response-reduction model computed from the raw CR responses.
module tb_ccu_ctrl_snoop_dispatch;
    import ccu_ctrl_snoop_dispatch_pkg::*;

    localparam int N = 4;
    localparam logic [2:0] ST_SEND_AC = 3'd1;
    localparam logic [2:0] ST_WAIT_CR = 3'd2;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b1;
    mst_req_t              req_i = '0;
    logic [1:0]            initiator_i = '0;
    logic                  req_valid_i = 1'b0;
    logic                  req_ready_o;
    snoop_ac_t [N-1:0]     ac_o;
    logic [N-1:0]          ac_valid_o;
    logic [N-1:0]          ac_ready_i = '0;
    snoop_cr_t [N-1:0]     cr_i = '0;
    logic [N-1:0]          cr_valid_i = '0;
    logic [N-1:0]          cr_ready_o;
    mst_req_t              ccu_req_holder_o;
    logic                  su_valid_o;
    logic                  su_ready_i = 1'b0;
    su_op_e                su_op_o;
    logic                  shared_o, dirty_o;
    logic [N-1:0]          data_available_o;
    logic [1:0]            first_responder_o;
    logic                  mem_valid_o;
    logic                  mem_ready_i = 1'b0;
    logic [2:0]            dbg_state_o;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0]   resp_t[N];
    int           ac_start[N];
    int           cr_start[N];
    logic [N-1:0] acv_hist[48];
    logic [N-1:0] crr_hist[48];
    logic [2:0]   st_hist[48];
    int           first_acv, disp_cyc;
    bit           aborted;

    ccu_ctrl_snoop_dispatch #(.NoMstPorts(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .initiator_i(initiator_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .ac_o(ac_o),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .cr_i(cr_i),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .ccu_req_holder_o(ccu_req_holder_o),
        .su_valid_o(su_valid_o), .su_ready_i(su_ready_i), .su_op_o(su_op_o),
        .shared_o(shared_o), .dirty_o(dirty_o), .data_available_o(data_available_o),
        .first_responder_o(first_responder_o), .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i), .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mst_req_t rand_req();
        mst_req_t r;
        r.ar.addr  = $urandom;
        r.ar.snoop = 4'($urandom);
        r.ar.prot  = 3'($urandom);
        r.ar.id    = 4'($urandom);
        return r;
    endfunction

    task automatic reset_and_check(input string tag);
        rst_ni = 1'b0;
        req_valid_i = 1'b0; ac_ready_i = '0; cr_valid_i = '0;
        su_ready_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        chk({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        chk({tag, "_ac_valid"}, 64'(ac_valid_o), 64'd0);
        chk({tag, "_cr_ready"}, 64'(cr_ready_o), 64'd0);
        chk({tag, "_su_valid"}, 64'(su_valid_o), 64'd0);
        chk({tag, "_mem_valid"}, 64'(mem_valid_o), 64'd0);
        chk({tag, "_shared"}, 64'(shared_o), 64'd0);
        chk({tag, "_dirty"}, 64'(dirty_o), 64'd0);
        chk({tag, "_data_avail"}, 64'(data_available_o), 64'd0);
        chk({tag, "_first_resp"}, 64'(first_responder_o), 64'd0);
        chk({tag, "_holder"}, 64'(ccu_req_holder_o), 64'd0);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    // One full transaction; cycle 0 is the accept cycle, readiness comes from the start tables.
    task automatic run_txn(input logic [1:0] init, input mst_req_t req, input int hold,
                           input bit keep_valid, input int rst_at);
        logic [N-1:0] exp_data, ac_seen, cr_seen, pend;
        logic         exp_sh, exp_dt, exp_su;
        logic [1:0]   exp_first;
        int viol_init, viol_drop, viol_early, viol_rdy, viol_pay, viol_hold;
        exp_data = '0; exp_sh = 1'b0; exp_dt = 1'b0; exp_first = '0;
        viol_init = 0; viol_drop = 0; viol_early = 0; viol_rdy = 0; viol_pay = 0; viol_hold = 0;
        for (int i = 0; i < N; i++) begin
            if (i != int'(init)) begin
                exp_data[i] = resp_t[i][0] & ~resp_t[i][1];
                exp_sh = exp_sh | resp_t[i][3];
                exp_dt = exp_dt | resp_t[i][2];
            end
        end
        for (int i = N - 1; i >= 0; i--) if (exp_data[i]) exp_first = 2'(i);
        exp_su = |exp_data;
        ac_seen = '0; cr_seen = '0; pend = '0;
        first_acv = -1; disp_cyc = -1; aborted = 1'b0;

        req_i = req; initiator_i = init; req_valid_i = 1'b1;
        #1;
        chk("req_ready_idle", 64'(req_ready_o), 64'd1);
        @(posedge clk_i); #1;
        if (!keep_valid) req_valid_i = 1'b0;

        for (int c = 1; c < 48; c++) begin
            for (int i = 0; i < N; i++) begin
                ac_ready_i[i] = (c >= ac_start[i]);
                cr_valid_i[i] = (c >= cr_start[i]) && !cr_seen[i] && (i != int'(init));
                cr_i[i].resp  = resp_t[i];
            end
            #1;
            acv_hist[c] = ac_valid_o; crr_hist[c] = cr_ready_o; st_hist[c] = dbg_state_o;
            if (ac_valid_o[init]) viol_init++;
            if ((pend & ~ac_valid_o) != '0) viol_drop++;
            if ((cr_ready_o & ~ac_seen) != '0) viol_early++;
            if (req_ready_o) viol_rdy++;
            if (ac_valid_o != '0 && first_acv < 0) first_acv = c;
            for (int i = 0; i < N; i++) begin
                if (ac_valid_o[i] && (ac_o[i].addr !== req.ar.addr || ac_o[i].snoop !== req.ar.snoop
                                      || ac_o[i].prot !== req.ar.prot)) viol_pay++;
            end
            if (c == rst_at) begin aborted = 1'b1; break; end
            if (su_valid_o || mem_valid_o) begin disp_cyc = c; break; end
            pend    = ac_valid_o & ~ac_ready_i;
            ac_seen = ac_seen | (ac_valid_o & ac_ready_i);
            cr_seen = cr_seen | (cr_ready_o & cr_valid_i);
            @(posedge clk_i); #1;
        end
        ac_ready_i = '0; cr_valid_i = '0;

        chk("no_ac_to_initiator", 64'(viol_init), 64'd0);
        chk("ac_valid_held", 64'(viol_drop), 64'd0);
        chk("cr_after_ac", 64'(viol_early), 64'd0);
        chk("req_ready_busy", 64'(viol_rdy), 64'd0);
        chk("ac_payload", 64'(viol_pay), 64'd0);
        if (aborted) return;
        chk("dispatch_timeout", 64'(disp_cyc < 0), 64'd0);
        if (disp_cyc < 0) return;

        chk("route_su", 64'(su_valid_o), 64'(exp_su));
        chk("route_mem", 64'(mem_valid_o), 64'(!exp_su));
        chk("holder", 64'(ccu_req_holder_o), 64'(req));
        chk("data_avail", 64'(data_available_o), 64'(exp_data));
        if (exp_su) begin
            chk("su_op", 64'(su_op_o), 64'(READ_SNP_DATA));
            chk("shared", 64'(shared_o), 64'(exp_sh));
            chk("dirty", 64'(dirty_o), 64'(exp_dt));
            chk("first_resp", 64'(first_responder_o), 64'(exp_first));
        end

        for (int h = 0; h <= hold; h++) begin
            su_ready_i  = (h == hold);
            mem_ready_i = (h == hold);
            #1;
            if (!(exp_su ? su_valid_o : mem_valid_o) || ccu_req_holder_o !== req
                || data_available_o !== exp_data || req_ready_o) viol_hold++;
            @(posedge clk_i); #1;
        end
        su_ready_i = 1'b0; mem_ready_i = 1'b0;
        chk("dispatch_stable", 64'(viol_hold), 64'd0);
        chk("idle_after_hs", 64'(req_ready_o), 64'd1);
        chk("valids_dropped", 64'({su_valid_o, mem_valid_o}), 64'd0);
    endtask

    task automatic set_starts(input int ac_s, input int cr_s);
        for (int i = 0; i < N; i++) begin
            ac_start[i] = ac_s;
            cr_start[i] = cr_s;
        end
    endtask

    initial begin
        reset_and_check("reset");

        // Full-cache-hit latency with every AC/CR ready
        set_starts(1, 1);
        resp_t[0] = 5'b00000; resp_t[1] = 5'b01001; resp_t[2] = 5'b00000; resp_t[3] = 5'b00101;
        run_txn(2'd0, rand_req(), 0, 1'b0, 0);
        chk("t1_ac_cycle", 64'(first_acv), 64'd1);
        chk("t1_su_cycle", 64'(disp_cyc), 64'd3);

        // Snoop miss held on the memory side for five cycles
        set_starts(1, 1);
        for (int i = 0; i < N; i++) resp_t[i] = 5'b00000;
        run_txn(2'd2, rand_req(), 5, 1'b0, 0);

        // Staggered AC readiness, port 3 CR offered before its AC has registered
        ac_start[0] = 1; ac_start[1] = 4; ac_start[2] = 6; ac_start[3] = 1;
        cr_start[0] = 1; cr_start[1] = 5; cr_start[2] = 8; cr_start[3] = 1;
        resp_t[1] = 5'b00001; resp_t[2] = 5'b01000; resp_t[3] = 5'b00100;
        run_txn(2'd0, rand_req(), 1, 1'b0, 0);
        chk("t3_cr_ready3_c1", 64'(crr_hist[1][3]), 64'd0);
        chk("t3_cr_ready3_c2", 64'(crr_hist[2][3]), 64'd1);
        chk("t3_state_c6", 64'(st_hist[6]), 64'(ST_SEND_AC));
        chk("t3_state_c7", 64'(st_hist[7]), 64'(ST_WAIT_CR));

        // Data with error bit counts as no data
        set_starts(1, 2);
        for (int i = 0; i < N; i++) resp_t[i] = 5'b00000;
        resp_t[2] = 5'b00011;
        run_txn(2'd1, rand_req(), 0, 1'b0, 0);
        chk("t4_went_mem", 64'(disp_cyc > 0 && mem_ready_i == 1'b0), 64'd1);

        // Snoop unit stalls three cycles while the next request is already waiting
        set_starts(1, 1);
        for (int i = 0; i < N; i++) resp_t[i] = 5'b00001;
        run_txn(2'd3, rand_req(), 3, 1'b1, 0);
        resp_t[0] = 5'b00000; resp_t[1] = 5'b00000; resp_t[2] = 5'b01101; resp_t[3] = 5'b00001;
        run_txn(2'd1, rand_req(), 0, 1'b0, 0);
        chk("t5_second_ac_cycle", 64'(first_acv), 64'd1);

        // Reset in WAIT_CR with two of three CRs collected
        set_starts(1, 1);
        cr_start[3] = 99;
        resp_t[0] = 5'b00000; resp_t[1] = 5'b01001; resp_t[2] = 5'b00101; resp_t[3] = 5'b00000;
        run_txn(2'd0, rand_req(), 0, 1'b0, 3);
        chk("t6_pre_rst_state", 64'(st_hist[3]), 64'(ST_WAIT_CR));
        chk("t6_pending_cr", 64'(crr_hist[3]), 64'b1000);
        reset_and_check("midrst");
        set_starts(1, 1);
        resp_t[1] = 5'b00000; resp_t[2] = 5'b00000; resp_t[3] = 5'b00001;
        run_txn(2'd0, rand_req(), 0, 1'b0, 0);
        chk("t6_restart_ac_cycle", 64'(first_acv), 64'd1);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                resp_t[i] = 5'($urandom);
                if ($urandom_range(0, 1) == 1) resp_t[i][0] = 1'b0;
                ac_start[i] = $urandom_range(1, 5);
                cr_start[i] = $urandom_range(1, 8);
            end
            run_txn(2'($urandom), rand_req(), $urandom_range(0, 3), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
